// File: rtl/apb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : apb_pkg                                                 |
// | Brief  : Shared types and constants for the APB master bridge.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package apb_pkg;

  // Bridge transfer phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Each slave owns a 4 KB slot
  localparam int APB_SLOT_BITS = 12;

  // Width of a slave index; a single slave still gets one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : apb_addr_decoder                                        |
// | Brief  : Maps a byte address onto a peripheral slot: hit + index.|
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          IDX_W     = 2
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Size of the whole peripheral region in bytes
  localparam logic [31:0] c_region = 32'(NUM_SLV) << APB_SLOT_BITS;

  logic [31:0] w_off;

  // Offset into the region; the range test on the offset avoids overflow of BASE+size
  always_comb begin
    w_off = addr - BASE_ADDR;
    hit   = (addr >= BASE_ADDR) && (w_off < c_region);
    idx   = w_off[APB_SLOT_BITS +: IDX_W];
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : apb_master_bridge                                       |
// | Brief  : Core data-bus request -> APB3 SETUP/ACCESS transfer,    |
// |          one-hot slave select, read-back mux and stall timeout.  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic                   PENABLE,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY
);

  localparam int IDX_W = idx_width(NUM_SLV);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit c_to_en = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_to_last = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e         r_state;
  logic               r_hit;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_prdata [NUM_SLV];
  logic               w_sel_ready;
  logic [31:0]        w_sel_rdata;
  logic [NUM_SLV-1:0] w_dec_sel;
  logic               w_timeout;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr (addr),
    .hit  (w_hit),
    .idx  (w_idx)
  );

  // Split the flat read-data bus into per-slave words
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_prdata
    assign w_prdata[i] = PRDATA[32*i +: 32];
  end

  // Response mux from the latched slave, select pattern for a new request, stall limit
  always_comb begin
    w_sel_ready = PREADY[r_idx];
    w_sel_rdata = w_prdata[r_idx];
    w_dec_sel   = w_hit ? (NUM_SLV'(1) << w_idx) : '0;
    w_timeout   = c_to_en && (r_cnt == c_to_last);
  end

  // Transfer sequencer with registered APB and completion outputs
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      case (r_state)
        IDLE: begin
          if (transfer) begin
            PADDR   <= addr;
            PWDATA  <= wdata;
            PWRITE  <= write;
            r_hit   <= w_hit;
            r_idx   <= w_idx;
            PSEL    <= w_dec_sel;
            PENABLE <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (!r_hit || w_sel_ready || w_timeout) begin
            r_state <= IDLE;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            r_cnt   <= '0;
            ready   <= 1'b1;
            err     <= !r_hit || !w_sel_ready;
            if (r_hit && w_sel_ready && !PWRITE) begin
              rdata <= w_sel_rdata;
            end
          end else if (c_to_en) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          PSEL    <= '0;
          PENABLE <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_apb_master_bridge                                    |
// | Brief  : Directed self-checking bench for apb_master_bridge.     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_apb_master_bridge;

  logic         PCLK;
  logic         PRESET;
  logic         transfer;
  logic         write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic         PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY;

  int checks;
  int errors;
  int n;

  apb_master_bridge #(
    .NUM_SLV   (4),
    .BASE_ADDR (32'h1000_0000),
    .TIMEOUT   (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one clock; inputs are driven and outputs sampled at the falling edge
  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    PREADY   = '0;
    PRDATA   = {32'hCCCC_0003, 32'hBBBB_0002, 32'h0000_00A5, 32'hAAAA_0000};
    step();
    step();

    // Reset state
    chk("rst_psel",    {28'd0, PSEL}, 32'h0);
    chk("rst_penable", {31'd0, PENABLE}, 32'h0);
    chk("rst_pwrite",  {31'd0, PWRITE}, 32'h0);
    chk("rst_paddr",   PADDR, 32'h0);
    chk("rst_pwdata",  PWDATA, 32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_ready",   {31'd0, ready}, 32'h0);
    chk("rst_err",     {31'd0, err}, 32'h0);
    PRESET = 1'b0;
    step();

    // 1: write to slave 0, PREADY one cycle late -> ready in cycle 4
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h0000_00FF;
    step();  // cycle 1
    transfer = 1'b0;
    chk("t1_c1_psel",    {28'd0, PSEL}, 32'h1);
    chk("t1_c1_penable", {31'd0, PENABLE}, 32'h0);
    chk("t1_c1_paddr",   PADDR, 32'h1000_0000);
    chk("t1_c1_pwdata",  PWDATA, 32'h0000_00FF);
    chk("t1_c1_pwrite",  {31'd0, PWRITE}, 32'h1);
    step();  // cycle 2
    chk("t1_c2_penable", {31'd0, PENABLE}, 32'h1);
    chk("t1_c2_ready",   {31'd0, ready}, 32'h0);
    step();  // cycle 3
    chk("t1_c3_penable", {31'd0, PENABLE}, 32'h1);
    chk("t1_c3_psel",    {28'd0, PSEL}, 32'h1);
    chk("t1_c3_ready",   {31'd0, ready}, 32'h0);
    PREADY = 4'b0001;
    step();  // cycle 4
    PREADY = 4'b0000;
    chk("t1_c4_ready",   {31'd0, ready}, 32'h1);
    chk("t1_c4_err",     {31'd0, err}, 32'h0);
    chk("t1_c4_rdata",   rdata, 32'h0);
    chk("t1_c4_psel",    {28'd0, PSEL}, 32'h0);
    chk("t1_c4_penable", {31'd0, PENABLE}, 32'h0);
    step();  // cycle 5
    chk("t1_c5_ready",   {31'd0, ready}, 32'h0);

    // 2: zero-wait read from slave 1
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_1004; wdata = 32'h0;
    PREADY = 4'b0010;
    step();  // cycle 1
    transfer = 1'b0;
    chk("t2_c1_psel",    {28'd0, PSEL}, 32'h2);
    chk("t2_c1_paddr",   PADDR, 32'h1000_1004);
    chk("t2_c1_pwrite",  {31'd0, PWRITE}, 32'h0);
    step();  // cycle 2
    chk("t2_c2_penable", {31'd0, PENABLE}, 32'h1);
    step();  // cycle 3
    PREADY = 4'b0000;
    chk("t2_c3_ready",   {31'd0, ready}, 32'h1);
    chk("t2_c3_err",     {31'd0, err}, 32'h0);
    chk("t2_c3_rdata",   rdata, 32'h0000_00A5);
    step();
    chk("t2_c4_rdata",   rdata, 32'h0);

    // 3: decode miss completes with error after one ACCESS cycle
    transfer = 1'b1; write = 1'b0; addr = 32'h2000_0000;
    PREADY = 4'b1111;
    step();  // cycle 1
    transfer = 1'b0;
    chk("t3_c1_psel",    {28'd0, PSEL}, 32'h0);
    chk("t3_c1_penable", {31'd0, PENABLE}, 32'h0);
    step();  // cycle 2
    chk("t3_c2_penable", {31'd0, PENABLE}, 32'h1);
    chk("t3_c2_psel",    {28'd0, PSEL}, 32'h0);
    step();  // cycle 3
    PREADY = 4'b0000;
    chk("t3_c3_ready",   {31'd0, ready}, 32'h1);
    chk("t3_c3_err",     {31'd0, err}, 32'h1);
    chk("t3_c3_rdata",   rdata, 32'h0);
    chk("t3_c3_penable", {31'd0, PENABLE}, 32'h0);
    step();

    // 4: slave 2 never ready, others ready (must be ignored) -> 16 ACCESS cycles
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
    PREADY = 4'b1011;
    step();  // cycle 1
    transfer = 1'b0;
    chk("t4_c1_psel", {28'd0, PSEL}, 32'h4);
    step();  // cycle 2, first ACCESS cycle
    n = 0;
    while (PENABLE && n < 40) begin
      n++;
      step();
    end
    chk("t4_access_cycles", n, 32'd16);
    chk("t4_ready", {31'd0, ready}, 32'h1);
    chk("t4_err",   {31'd0, err}, 32'h1);
    chk("t4_psel",  {28'd0, PSEL}, 32'h0);
    chk("t4_rdata", rdata, 32'h0);
    PREADY = 4'b0000;
    step();

    // 5: transfer held high across two writes to slave 3
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_3010; wdata = 32'h1111_2222;
    PREADY = 4'b1000;
    step();  // cycle 1 SETUP
    chk("t5a_psel",  {28'd0, PSEL}, 32'h8);
    chk("t5a_paddr", PADDR, 32'h1000_3010);
    addr = 32'hDEAD_BEEF; wdata = 32'h0BAD_0BAD;
    step();  // cycle 2 ACCESS
    chk("t5a_paddr_hold",  PADDR, 32'h1000_3010);
    chk("t5a_pwdata_hold", PWDATA, 32'h1111_2222);
    chk("t5a_ready_low",   {31'd0, ready}, 32'h0);
    step();  // cycle 3 ready, IDLE re-samples transfer
    chk("t5a_ready", {31'd0, ready}, 32'h1);
    chk("t5a_psel0", {28'd0, PSEL}, 32'h0);
    addr = 32'h1000_3020; wdata = 32'h3333_4444;
    step();  // cycle 4 second SETUP
    chk("t5b_ready_low", {31'd0, ready}, 32'h0);
    chk("t5b_psel",      {28'd0, PSEL}, 32'h8);
    chk("t5b_paddr",     PADDR, 32'h1000_3020);
    chk("t5b_pwdata",    PWDATA, 32'h3333_4444);
    addr = 32'h0; wdata = 32'h0;
    step();  // cycle 5 ACCESS
    transfer = 1'b0;
    chk("t5b_paddr_hold",  PADDR, 32'h1000_3020);
    chk("t5b_pwdata_hold", PWDATA, 32'h3333_4444);
    step();  // cycle 6
    chk("t5b_ready", {31'd0, ready}, 32'h1);
    step();  // cycle 7: no third transaction
    chk("t5_no_third_psel",  {28'd0, PSEL}, 32'h0);
    chk("t5_no_third_ready", {31'd0, ready}, 32'h0);
    PREADY = 4'b0000;

    // 6: asynchronous reset during ACCESS, then a normal write
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_1000; wdata = 32'h5555_AAAA;
    step();  // cycle 1
    transfer = 1'b0;
    step();  // cycle 2 ACCESS
    chk("t6_access", {31'd0, PENABLE}, 32'h1);
    PRESET = 1'b1;
    #1;
    chk("t6_rst_psel",    {28'd0, PSEL}, 32'h0);
    chk("t6_rst_penable", {31'd0, PENABLE}, 32'h0);
    chk("t6_rst_ready",   {31'd0, ready}, 32'h0);
    step();
    PRESET = 1'b0;
    step();
    chk("t6_post_ready", {31'd0, ready}, 32'h0);
    chk("t6_post_psel",  {28'd0, PSEL}, 32'h0);
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_0008; wdata = 32'h0000_1234;
    PREADY = 4'b0001;
    step();  // cycle 1
    transfer = 1'b0;
    chk("t6_new_psel",   {28'd0, PSEL}, 32'h1);
    chk("t6_new_pwdata", PWDATA, 32'h0000_1234);
    step();  // cycle 2
    step();  // cycle 3
    PREADY = 4'b0000;
    chk("t6_new_ready", {31'd0, ready}, 32'h1);
    chk("t6_new_err",   {31'd0, err}, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
